// File: rtl/cam_axis_packetizer.sv
// CameraLink timing (FVAL/LVAL/DVAL) + N-tap pixel bus to AXI4-Stream video.
// One-beat hold-back marks tlast; elastic FWFT FIFO with overflow/resync policy.

module cam_axis_packetizer_lane #(
  parameter int PIX_WIDTH  = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                 axis_clk,
  input  logic                 aresetn,
  input  logic                 i_load,
  input  logic [PIX_WIDTH-1:0] i_pix,
  input  logic                 i_wr,
  input  logic [AW-1:0]        i_waddr,
  input  logic [AW-1:0]        i_raddr,
  output logic [PIX_WIDTH-1:0] o_pix
);

  logic [PIX_WIDTH-1:0] r_hold;
  logic [PIX_WIDTH-1:0] r_mem [FIFO_DEPTH];

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn)    r_hold <= '0;
    else if (i_load) r_hold <= i_pix;
  end

  // FIFO storage column for this tap; written from the hold register
  always_ff @(posedge axis_clk) begin
    if (i_wr) r_mem[i_waddr] <= r_hold;
  end

  assign o_pix = r_mem[i_raddr];

endmodule

module cam_axis_packetizer #(
  parameter int TAPS       = 3,
  parameter int PIX_WIDTH  = 8,
  parameter int DATA_WIDTH = TAPS*PIX_WIDTH,
  parameter int FIFO_DEPTH = 64,
  parameter int LINE_BEATS = 0,
  parameter int DROP_FRAME = 1
) (
  input  logic                        axis_clk,
  input  logic                        aresetn,
  input  logic                        cam_en,
  input  logic                        cam_fval,
  input  logic                        cam_lval,
  input  logic                        cam_dval,
  input  logic [DATA_WIDTH-1:0]       cam_pix,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  output logic                        overflow,
  output logic                        line_len_err,
  output logic [15:0]                 dropped_frames,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]   LB      = 16'(LINE_BEATS);
  localparam bit            DROP_EN = (DROP_FRAME != 0);

  typedef enum logic [1:0] {WAIT_SOF, IN_FRAME, DROP} state_t;

  state_t r_state, w_state_nxt;

  logic                               r_primed, r_fval_d, r_lval_d;
  logic                               r_sof, r_hold_vld, r_hold_user;
  logic [AW:0]                        r_wptr, r_rptr;
  logic [1:0]                         r_sb_mem [FIFO_DEPTH];
  logic [15:0]                        r_beat_cnt, r_drop_cnt;
  logic                               r_ovf, r_llerr;

  logic [TAPS-1:0][PIX_WIDTH-1:0]     w_pix, w_lane_pix;
  logic                               w_fval_rise, w_fval_fall, w_lval_rise, w_lval_fall;
  logic                               w_beat, w_accept, w_push, w_push_last;
  logic                               w_rd, w_wr, w_full, w_ovf;
  logic [AW:0]                        w_level;
  logic [1:0]                         w_sb_out;

  assign w_pix = cam_pix;

  // Edges are only meaningful once one enabled sample has been seen since reset,
  // so a reset released mid-frame never looks like a frame start.
  assign w_fval_rise = cam_en & r_primed &  cam_fval & ~r_fval_d;
  assign w_fval_fall = cam_en & r_primed & ~cam_fval &  r_fval_d;
  assign w_lval_rise = cam_en & r_primed &  cam_lval & ~r_lval_d;
  assign w_lval_fall = cam_en & r_primed & ~cam_lval &  r_lval_d;

  assign w_beat      = cam_en & cam_fval & cam_lval & cam_dval;
  assign w_accept    = w_beat & (r_state == IN_FRAME);
  assign w_push      = (r_state == IN_FRAME) & r_hold_vld & (w_beat | w_lval_fall | w_fval_fall);
  assign w_push_last = ~w_beat;

  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == DEPTH_L);
  assign w_rd    = m_axis_tvalid & m_axis_tready;
  assign w_wr    = w_push & (~w_full | w_rd);
  assign w_ovf   = w_push & w_full & ~w_rd;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_SOF: if (w_fval_rise) w_state_nxt = IN_FRAME;
      IN_FRAME: begin
        if (w_fval_fall)            w_state_nxt = WAIT_SOF;
        else if (w_ovf && DROP_EN)  w_state_nxt = DROP;
      end
      DROP:     if (w_fval_fall) w_state_nxt = WAIT_SOF;
      default:  w_state_nxt = WAIT_SOF;
    endcase
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= WAIT_SOF;
      r_primed    <= 1'b0;
      r_fval_d    <= 1'b0;
      r_lval_d    <= 1'b0;
      r_sof       <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_user <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_beat_cnt  <= '0;
      r_drop_cnt  <= '0;
      r_ovf       <= 1'b0;
      r_llerr     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (cam_en) begin
        r_primed <= 1'b1;
        r_fval_d <= cam_fval;
        r_lval_d <= cam_lval;
      end

      if (r_state == WAIT_SOF && w_fval_rise) r_sof <= 1'b1;
      else if (w_accept)                      r_sof <= 1'b0;

      // Overflow under frame-drop empties the hold so the partial line is never closed
      if (w_ovf && DROP_EN) begin
        r_hold_vld <= 1'b0;
      end else if (w_accept) begin
        r_hold_vld  <= 1'b1;
        r_hold_user <= r_sof;
      end else if (w_push) begin
        r_hold_vld <= 1'b0;
      end

      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;

      if (w_lval_rise)                            r_beat_cnt <= {15'd0, w_accept};
      else if (w_accept && r_beat_cnt != 16'hFFFF) r_beat_cnt <= r_beat_cnt + 16'd1;

      if (w_ovf && DROP_EN && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;

      r_ovf   <= w_ovf;
      r_llerr <= (r_state == IN_FRAME) && w_lval_fall && (LB != 16'd0) &&
                 (r_beat_cnt != 16'd0) && (r_beat_cnt != LB);
    end
  end

  always_ff @(posedge axis_clk) begin
    if (w_wr) r_sb_mem[r_wptr[AW-1:0]] <= {r_hold_user, w_push_last};
  end

  assign w_sb_out = r_sb_mem[r_rptr[AW-1:0]];

  for (genvar t = 0; t < TAPS; t++) begin : g_lane
    cam_axis_packetizer_lane #(
      .PIX_WIDTH  (PIX_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lane (
      .axis_clk (axis_clk),
      .aresetn  (aresetn),
      .i_load   (w_accept),
      .i_pix    (w_pix[t]),
      .i_wr     (w_wr),
      .i_waddr  (r_wptr[AW-1:0]),
      .i_raddr  (r_rptr[AW-1:0]),
      .o_pix    (w_lane_pix[t])
    );
  end

  // Payload is masked while empty so every output reads 0 straight out of reset
  assign m_axis_tvalid  = (w_level != '0);
  assign m_axis_tdata   = m_axis_tvalid ? w_lane_pix : '0;
  assign m_axis_tuser   = m_axis_tvalid & w_sb_out[1];
  assign m_axis_tlast   = m_axis_tvalid & w_sb_out[0];
  assign overflow       = r_ovf;
  assign line_len_err   = r_llerr;
  assign dropped_frames = r_drop_cnt;
  assign fifo_level     = w_level;

endmodule

// File: tb/tb_cam_axis_packetizer.sv
// Scoreboard bench: two packetizers (frame-drop and beat-drop policies) share stimulus.
module tb_cam_axis_packetizer;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          en = 1'b0, fval = 1'b0, lval = 1'b0, dval = 1'b0;
  logic [DW-1:0] pix = '0;
  logic          tready = 1'b0, tready_fix = 1'b0, rnd = 1'b0, en_tog = 1'b0;

  logic [DW-1:0] td_a, td_b;
  logic          tv_a, tv_b, tl_a, tl_b, tu_a, tu_b, ov_a, ov_b, le_a, le_b;
  logic [15:0]   df_a, df_b;
  logic [3:0]    lvl_a, lvl_b;

  int errors = 0, checks = 0;
  int ovf_a = 0, ovf_b = 0, lle_a = 0, lle_b = 0;
  logic [DW+1:0] qa[$], qb[$];
  logic          stall_a = 1'b0, stall_b = 1'b0;
  logic [DW+2:0] prev_a, prev_b;

  always #5 clk = ~clk;

  cam_axis_packetizer #(.TAPS(3), .PIX_WIDTH(8), .FIFO_DEPTH(8), .LINE_BEATS(4), .DROP_FRAME(1)) u_dut_a (
    .axis_clk(clk), .aresetn(rstn), .cam_en(en), .cam_fval(fval), .cam_lval(lval), .cam_dval(dval),
    .cam_pix(pix), .m_axis_tdata(td_a), .m_axis_tvalid(tv_a), .m_axis_tready(tready),
    .m_axis_tlast(tl_a), .m_axis_tuser(tu_a), .overflow(ov_a), .line_len_err(le_a),
    .dropped_frames(df_a), .fifo_level(lvl_a));

  cam_axis_packetizer #(.TAPS(3), .PIX_WIDTH(8), .FIFO_DEPTH(8), .LINE_BEATS(4), .DROP_FRAME(0)) u_dut_b (
    .axis_clk(clk), .aresetn(rstn), .cam_en(en), .cam_fval(fval), .cam_lval(lval), .cam_dval(dval),
    .cam_pix(pix), .m_axis_tdata(td_b), .m_axis_tvalid(tv_b), .m_axis_tready(tready),
    .m_axis_tlast(tl_b), .m_axis_tuser(tu_b), .overflow(ov_b), .line_len_err(le_b),
    .dropped_frames(df_b), .fifo_level(lvl_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    tready = rnd ? 1'($urandom_range(0, 1)) : tready_fix;
  end

  // Output monitors: pop/compare on handshake, payload stability while stalled
  always @(negedge clk) begin
    if (!rstn) begin
      stall_a = 1'b0;
      stall_b = 1'b0;
    end else begin
      if (ov_a) ovf_a++;
      if (ov_b) ovf_b++;
      if (le_a) lle_a++;
      if (le_b) lle_b++;
      if (stall_a) chk("A_stall_hold", 32'({tv_a, tu_a, tl_a, td_a}), 32'(prev_a));
      if (stall_b) chk("B_stall_hold", 32'({tv_b, tu_b, tl_b, td_b}), 32'(prev_b));
      if (tv_a && tready) begin
        if (qa.size() == 0) chk("A_extra_beat", 32'(qa.size()), 32'd1);
        else chk("A_beat", 32'({tu_a, tl_a, td_a}), 32'(qa.pop_front()));
      end
      if (tv_b && tready) begin
        if (qb.size() == 0) chk("B_extra_beat", 32'(qb.size()), 32'd1);
        else chk("B_beat", 32'({tu_b, tl_b, td_b}), 32'(qb.pop_front()));
      end
      stall_a = tv_a & ~tready;
      stall_b = tv_b & ~tready;
      prev_a  = {tv_a, tu_a, tl_a, td_a};
      prev_b  = {tv_b, tu_b, tl_b, td_b};
    end
  end

  task automatic cyc(input logic f, input logic l, input logic d, input logic [DW-1:0] p);
    if (en_tog) begin
      en = 1'b0; fval = 1'($urandom); lval = 1'($urandom); dval = 1'($urandom); pix = DW'($urandom);
      @(posedge clk); #1;
    end
    en = 1'b1; fval = f; lval = l; dval = d; pix = p;
    @(posedge clk); #1;
  endtask

  task automatic expb(input logic u, input logic l, input logic [DW-1:0] d, input bit ea, input bit eb);
    if (ea) qa.push_back({u, l, d});
    if (eb) qb.push_back({u, l, d});
  endtask

  task automatic frame(input int nl, input int nb, input int nb_last, input logic [DW-1:0] base,
                       input bit ea, input bit eb);
    int k = 0;
    cyc(1, 0, 0, '0);
    for (int li = 0; li < nl; li++) begin
      int n = (li == nl - 1) ? nb_last : nb;
      for (int b = 0; b < n; b++) begin
        expb(k == 0, b == n - 1, base + DW'(k), ea, eb);
        cyc(1, 1, 1, base + DW'(k));
        k++;
      end
      cyc(1, 0, 0, '0);
    end
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || lvl_a != 0 || lvl_b != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drain_qa"}, 32'(qa.size()), 32'd0);
    chk({tag, "_drain_qb"}, 32'(qb.size()), 32'd0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_tvalid"}, 32'(tv_a), 32'd0);
    chk({tag, "_tdata"},  32'(td_a), 32'd0);
    chk({tag, "_tlast"},  32'(tl_a), 32'd0);
    chk({tag, "_tuser"},  32'(tu_a), 32'd0);
    chk({tag, "_ovf"},    32'(ov_a), 32'd0);
    chk({tag, "_llerr"},  32'(le_a), 32'd0);
    chk({tag, "_dropped"},32'(df_a), 32'd0);
    chk({tag, "_level"},  32'(lvl_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rstn = 1'b0;
    #1 chk_idle_zero("reset");
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) cyc(0, 0, 0, '0);

    // 3 lines x 4 beats, sink always ready
    tready_fix = 1'b1;
    cyc(0, 0, 0, '0);
    frame(3, 4, 4, 24'h000001, 1, 1);
    drain("t1");
    chk("t1_llerr_a", 32'(lle_a), 32'd0);
    chk("t1_ovf_a",   32'(ovf_a), 32'd0);

    // 20-beat line into an 8-deep FIFO with the sink stalled
    tready_fix = 1'b0;
    cyc(0, 0, 0, '0);
    for (int k = 0; k < 8; k++) expb(k == 0, 1'b0, 24'h000100 + DW'(k), 1, 1);
    frame(1, 20, 20, 24'h000100, 0, 0);
    chk("ovf_level_a",   32'(lvl_a), 32'd8);
    chk("ovf_level_b",   32'(lvl_b), 32'd8);
    chk("ovf_pulses_a",  32'(ovf_a), 32'd1);
    chk("ovf_pulses_b",  32'(ovf_b), 32'd12);
    chk("ovf_dropped_a", 32'(df_a),  32'd1);
    chk("ovf_dropped_b", 32'(df_b),  32'd0);
    chk("ovf_llerr_a",   32'(lle_a), 32'd0);
    chk("ovf_llerr_b",   32'(lle_b), 32'd1);
    tready_fix = 1'b1;
    drain("ovf");
    frame(1, 4, 4, 24'h000200, 1, 1);
    drain("resync");

    // short second line
    frame(2, 4, 3, 24'h000300, 1, 1);
    drain("short");
    chk("short_llerr_a", 32'(lle_a), 32'd1);
    chk("short_llerr_b", 32'(lle_b), 32'd2);

    // camera enable toggling, random sink backpressure, same content as the first run
    en_tog = 1'b1;
    rnd    = 1'b1;
    frame(3, 4, 4, 24'h000001, 1, 1);
    en_tog = 1'b0;
    drain("entog");
    rnd = 1'b0;
    cyc(0, 0, 0, '0);
    chk("entog_llerr_a", 32'(lle_a), 32'd1);

    // reset asserted and released in the middle of a line
    cyc(1, 0, 0, '0);
    cyc(1, 1, 1, 24'h000500);
    #2 rstn = 1'b0;
    #1 chk_idle_zero("midrst");
    @(posedge clk); #1;
    cyc(1, 1, 1, 24'h000501);
    cyc(1, 1, 1, 24'h000502);
    rstn = 1'b1;
    cyc(1, 1, 1, 24'h000503);
    cyc(1, 1, 1, 24'h000504);
    cyc(1, 0, 0, '0);
    for (int k = 0; k < 4; k++) cyc(1, 1, 1, 24'h000510 + DW'(k));
    cyc(1, 0, 0, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
    chk("midrst_tvalid_a", 32'(tv_a),  32'd0);
    chk("midrst_level_b",  32'(lvl_b), 32'd0);
    frame(2, 4, 4, 24'h000600, 1, 1);
    drain("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_axis_packetizer.md
Name: cam_axis_packetizer

Overview:
- Parametrised successor to the single-tap-group CameraLink-to-AXIS receiver.
- Converts parsed camera timing (FVAL/LVAL/DVAL) plus an N-tap pixel bus into an AXI4-Stream video packet stream: tuser marks start of frame (SoF), tlast marks end of line (EoL).
- Sits after the clock-domain crossing, so everything runs on one clock. The camera side is qualified by a clock enable.
- Adds three things the earlier block lacks:
  - configurable taps and pixel width;
  - an internal elastic FIFO of configurable depth;
  - overflow policy with frame resync, plus line-length checking and a dropped-frame counter.

Parameters:
TAPS, 3, pixel taps per beat (1..8); Base=3, Medium=6, Full=8
PIX_WIDTH, 8, bits per tap (8..16)
DATA_WIDTH, TAPS*PIX_WIDTH, m_axis_tdata width (derived; do not override)
FIFO_DEPTH, 64, FIFO entries; power of two, 4..1024
LINE_BEATS, 0, expected beats per line; 0 disables the length check
DROP_FRAME, 1, overflow policy: 1 = discard rest of frame and resync on next FVAL rise; 0 = discard the offending beat only

Ports:
axis_clk  in  1  sole clock
aresetn  in  1  asynchronous active-low reset
cam_en  in  1  camera sample enable; inputs are ignored when low
cam_fval  in  1  frame valid
cam_lval  in  1  line valid
cam_dval  in  1  data valid
cam_pix  in  DATA_WIDTH  taps packed; tap 0 in LSBs
m_axis_tdata  out  DATA_WIDTH  pixel beat
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready
m_axis_tlast  out  1  last beat of line
m_axis_tuser  out  1  first beat of frame
overflow  out  1  one-cycle pulse when a beat is discarded because the FIFO is full
line_len_err  out  1  one-cycle pulse when a line length differs from LINE_BEATS
dropped_frames  out  16  saturating count of frames truncated by overflow
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0; FIFO is empty.
  - State is WAIT_SOF, holding register is empty, counters are 0.
  - Outputs drop immediately on assertion of aresetn low.
- Input sampling only on cycles with cam_en=1. A "beat" is cam_en & cam_fval & cam_lval & cam_dval. Edge detection compares against the previous enabled sample.
- State machine:
  - WAIT_SOF: discard everything. On FVAL rising edge -> IN_FRAME, arm sof_flag.
  - IN_FRAME: accept beats. On FVAL falling edge -> WAIT_SOF.
  - Overflow with DROP_FRAME=1 -> DROP; discard until FVAL falls, then -> WAIT_SOF.
  - Mid-line entry after reset: WAIT_SOF guarantees the first output beat has tuser=1.
- Hold-back register (one beat): every accepted beat is held. The held beat is pushed into the FIFO with last=0 when the next beat arrives, or with last=1 on the enabled cycle where LVAL falls or FVAL falls.
  - LVAL falling in the same cycle as a beat is impossible (the beat requires lval=1).
  - The first beat after sof_flag is stored with user=1, which clears sof_flag.
- FIFO:
  - Entry = {user, last, data}.
  - Write when a push occurs and the FIFO is not full, or when a read happens in the same cycle (simultaneous read and write at full succeeds).
  - Read when m_axis_tvalid & m_axis_tready.
  - Output is first-word-fall-through: tvalid rises the cycle after the push into an empty FIFO.
  - tdata/tlast/tuser hold stable while tvalid & !tready. Pointers wrap modulo FIFO_DEPTH.
- Overflow (push while full, no simultaneous read):
  - overflow pulses and the beat is lost.
  - DROP_FRAME=1: dropped_frames increments (saturating at 0xFFFF) and state -> DROP. Beats already in the FIFO still drain. The partial line is not closed with tlast.
  - DROP_FRAME=0: continue in IN_FRAME.
- Line length:
  - A beat counter (16 bits, saturating) increments per accepted beat and clears on LVAL rise.
  - On LVAL fall with LINE_BEATS != 0 and count != LINE_BEATS, line_len_err pulses one cycle.
  - A line with zero beats produces no push and no error.
- FVAL falling with the holding register empty: no push.

Test Plan:
- TAPS=3, LINE_BEATS=4, tready=1, 3 lines of 4 beats with cam_pix=0x000001..0x00000C -> 12 beats in order; tuser=1 only on 0x000001; tlast=1 on beats 4, 8 and 12; line_len_err never asserted.
- Reset released mid-frame (FVAL=1, LVAL=1), then rest of that frame plus one full frame -> no output until the next FVAL rise; first output beat has tuser=1.
- FIFO_DEPTH=8, tready=0 for a 20-beat single-line frame, then tready=1 -> exactly 8 beats out (FIFO) with the 9th accepted beat left in the holding register and discarded; overflow pulses once; dropped_frames=1; the next frame is output intact with tuser=1.
- DROP_FRAME=0, same stimulus -> overflow pulses on each lost beat; output continues after drain; dropped_frames=0.
- Second line of 3 beats with LINE_BEATS=4 -> line_len_err pulses once at that LVAL fall; tlast still on the 3rd beat.
- cam_en toggling 1/0 every cycle, with inputs changed on cam_en=0 cycles -> output identical to the cam_en=1 run; random tready gives identical beat order with tdata stable while stalled.
